// File: rtl/qpsk_frame_pkg.sv
// Shared definitions for the QPSK 40-bit frame format: sync bytes, field
// positions, collector state encoding and the nibble checksum.
package qpsk_frame_pkg;

  localparam int FRAME_W = 40;

  localparam logic [7:0] SYNC_DATA = 8'hA5;
  localparam logic [7:0] SYNC_IDLE = 8'h5A;

  localparam int SYNC_LSB = 32;
  localparam int SEQ_LSB  = 28;
  localparam int B0_LSB   = 20;
  localparam int B1_LSB   = 12;
  localparam int B2_LSB   = 4;
  localparam int CHK_LSB  = 0;

  // The COLLECT encodings double as the buffer slot of the next byte.
  typedef enum logic [1:0] {
    ST_COLLECT0 = 2'd0,
    ST_COLLECT1 = 2'd1,
    ST_COLLECT2 = 2'd2,
    ST_FULL     = 2'd3
  } collect_state_e;

  function automatic logic [3:0] frame_chk(input logic [3:0] seq,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2);
    return seq ^ b0[7:4] ^ b0[3:0] ^ b1[7:4] ^ b1[3:0] ^ b2[7:4] ^ b2[3:0];
  endfunction

  function automatic logic [FRAME_W-1:0] frame_pack(input logic       is_data,
                                                    input logic [3:0] seq,
                                                    input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[SYNC_LSB +: 8] = is_data ? SYNC_DATA : SYNC_IDLE;
    f[SEQ_LSB  +: 4] = seq;
    f[B0_LSB   +: 8] = b0;
    f[B1_LSB   +: 8] = b1;
    f[B2_LSB   +: 8] = b2;
    f[CHK_LSB  +: 4] = frame_chk(seq, b0, b1, b2);
    return f;
  endfunction

endpackage

// File: rtl/qpsk_frame_timer.sv
// Free-running frame-period counter; flags the last cycle of each period.
module qpsk_frame_timer #(
  parameter int FRAME_CLKS = 400000,
  parameter int CNT_W      = 19
) (
  input  logic clk,
  input  logic rst_n,
  output logic boundary_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign boundary_o = (cnt_q == LAST);

endmodule

// File: rtl/qpsk_frame_builder.sv
// Collects three payload bytes and presents a 40-bit data or idle frame to the
// modulator once per frame period.
module qpsk_frame_builder
  import qpsk_frame_pkg::*;
#(
  parameter int FRAME_CLKS = 400000,
  parameter int CNT_W      = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic [FRAME_W-1:0] para_o,
  output logic               frame_tick_o,
  output logic               frame_is_data_o,
  output logic [15:0]        idle_cnt_o
);

  logic boundary;

  qpsk_frame_timer #(
    .FRAME_CLKS(FRAME_CLKS),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .boundary_o(boundary)
  );

  collect_state_e     state_q, state_d;
  logic [7:0]         buf_q [3];
  logic [3:0]         seq_q, seq_d;
  logic [FRAME_W-1:0] para_q, para_d;
  logic               data_q, data_d;
  logic               tick_q;
  logic [15:0]        idle_q, idle_d;
  logic               accept;

  assign byte_ready_o = rst_n & (state_q != ST_FULL);
  assign accept       = byte_valid_i & byte_ready_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    para_d  = para_q;
    data_d  = data_q;
    idle_d  = idle_q;

    if (boundary) begin
      if (state_q == ST_FULL) begin
        para_d  = frame_pack(1'b1, seq_q, buf_q[0], buf_q[1], buf_q[2]);
        data_d  = 1'b1;
        seq_d   = seq_q + 4'd1;
        state_d = ST_COLLECT0;
      end else begin
        para_d = frame_pack(1'b0, seq_q, 8'h00, 8'h00, 8'h00);
        data_d = 1'b0;
        if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;
      end
    end

    // accept is never set in FULL, so it cannot clash with the data load.
    if (accept) begin
      case (state_q)
        ST_COLLECT0: state_d = ST_COLLECT1;
        ST_COLLECT1: state_d = ST_COLLECT2;
        ST_COLLECT2: state_d = ST_FULL;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT0;
      seq_q   <= 4'd0;
      para_q  <= frame_pack(1'b0, 4'd0, 8'h00, 8'h00, 8'h00);
      data_q  <= 1'b0;
      tick_q  <= 1'b0;
      idle_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      para_q  <= para_d;
      data_q  <= data_d;
      tick_q  <= boundary;
      idle_q  <= idle_d;
    end
  end

  // NOTE: the byte buffer carries no reset; the FSM state decides which slots hold valid bytes.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state_q)
        ST_COLLECT0: buf_q[0] <= byte_i;
        ST_COLLECT1: buf_q[1] <= byte_i;
        ST_COLLECT2: buf_q[2] <= byte_i;
        default:     ;
      endcase
    end
  end

  assign para_o          = para_q;
  assign frame_is_data_o = data_q;
  assign frame_tick_o    = tick_q;
  assign idle_cnt_o      = idle_q;

endmodule

// File: tb/tb_qpsk_frame_builder.sv
// Self-checking bench for qpsk_frame_builder with a queue-based frame model.
module tb_qpsk_frame_builder;

  localparam int FRAME_CLKS = 20;
  localparam int CNT_W      = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [39:0] para_o;
  logic        frame_tick_o;
  logic        frame_is_data_o;
  logic [15:0] idle_cnt_o;

  qpsk_frame_builder #(
    .FRAME_CLKS(FRAME_CLKS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .para_o         (para_o),
    .frame_tick_o   (frame_tick_o),
    .frame_is_data_o(frame_is_data_o),
    .idle_cnt_o     (idle_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes waiting for the next frame, plus frame-level state.
  logic [7:0]  m_pend[$];
  int          m_pos;
  int          m_seq;
  int          m_idle;
  logic [39:0] m_para;
  logic        m_tick;
  logic        m_data;
  logic        last_acc;

  function automatic logic [39:0] model_frame(input logic is_data, input int seq,
                                              input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
    logic [39:0] f;
    logic [3:0]  x;
    f = {(is_data ? 8'hA5 : 8'h5A), 4'(seq), b0, b1, b2, 4'h0};
    x = 4'h0;
    for (int i = 1; i <= 7; i++) x = x ^ f[4*i +: 4];
    f[3:0] = x;
    return f;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_pos  = 0;
    m_seq  = 0;
    m_idle = 0;
    m_para = 40'h5A00000000;
    m_tick = 1'b0;
    m_data = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rst_val, input logic v, input logic [7:0] b);
    logic exp_ready;
    logic acc;
    rst_n        = rst_val;
    byte_valid_i = v;
    byte_i       = b;
    #1;
    exp_ready = rst_val && (m_pend.size() < 3);
    check("ready", byte_ready_o, exp_ready);
    acc = v && exp_ready;
    if (!rst_val) begin
      model_reset();
    end else begin
      m_tick = 1'b0;
      if (m_pos == FRAME_CLKS - 1) begin
        m_tick = 1'b1;
        if (m_pend.size() == 3) begin
          m_para = model_frame(1'b1, m_seq, m_pend[0], m_pend[1], m_pend[2]);
          m_data = 1'b1;
          m_pend.delete();
          m_seq = (m_seq + 1) % 16;
        end else begin
          m_para = model_frame(1'b0, m_seq, 8'h00, 8'h00, 8'h00);
          m_data = 1'b0;
          if (m_idle < 65535) m_idle++;
        end
      end
      if (acc) m_pend.push_back(b);
      m_pos = (m_pos + 1) % FRAME_CLKS;
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    check("para", para_o, m_para);
    check("tick", frame_tick_o, m_tick);
    check("is_data", frame_is_data_o, m_data);
    check("idle_cnt", idle_cnt_o, 40'(m_idle));
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] nb;
    model_reset();
    @(negedge clk);

    // Reset and idle frames with no input.
    do_reset(3);
    check("reset_para", para_o, 40'h5A00000000);
    run_idle(60);
    check("idle_after_3", idle_cnt_o, 40'd3);

    // First data frame, then an idle frame with SEQ = 1.
    do_reset(2);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    cycle(1'b1, 1'b1, 8'h33);
    run_idle(17);
    check("data_frame", para_o, 40'hA501122330);
    check("data_flag", frame_is_data_o, 1'b1);
    run_idle(20);
    check("idle_seq1", para_o, 40'h5A10000001);

    // Backpressure: valid held high with incrementing bytes across a SEQ wrap.
    do_reset(2);
    nb = 8'h00;
    for (int i = 0; i < FRAME_CLKS * 18; i++) begin
      cycle(1'b1, 1'b1, nb);
      if (last_acc) nb = nb + 8'd1;
    end

    // Third byte offered in the boundary cycle.
    do_reset(2);
    cycle(1'b1, 1'b1, 8'hAA);
    cycle(1'b1, 1'b1, 8'hBB);
    run_idle(17);
    cycle(1'b1, 1'b1, 8'hCC);
    check("race_idle", frame_is_data_o, 1'b0);
    check("race_full", byte_ready_o, 1'b0);
    run_idle(20);
    check("race_b2", 40'(para_o[11:4]), 40'hCC);

    // Reset with two bytes buffered discards them.
    do_reset(2);
    cycle(1'b1, 1'b1, 8'h91);
    cycle(1'b1, 1'b1, 8'h92);
    run_idle(3);
    do_reset(2);
    cycle(1'b1, 1'b1, 8'h41);
    cycle(1'b1, 1'b1, 8'h42);
    cycle(1'b1, 1'b1, 8'h43);
    run_idle(17);
    check("midreset_frame", para_o, 40'hA504142434);

    // Reset during the boundary cycle suppresses the load.
    do_reset(2);
    cycle(1'b1, 1'b1, 8'h01);
    cycle(1'b1, 1'b1, 8'h02);
    cycle(1'b1, 1'b1, 8'h03);
    run_idle(16);
    cycle(1'b0, 1'b0, 8'h00);
    check("bnd_reset_para", para_o, 40'h5A00000000);
    run_idle(20);

    // Random payloads and occasional resets.
    do_reset(2);
    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(0, 599) == 0)
        cycle(1'b0, 1'b0, 8'h00);
      else
        cycle(1'b1, ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
